f3_gpu: RTL and testbench
=========================

Name: f3_gpu

Overview:
- Parametrised successor of the f2-generation image viewer GPU. It maps a display scan address into a square image window and produces pixel ROM addresses and an image select for the mapper and image store.
- Applies mirror, rotation and negative to the displayed image.
- Animates a wipe transition between images.
- Accepts commands over a valid/ready handshake with a one-entry pending buffer, so no command is lost while a transition is running.

Parameters:
- IMG_BITS, 4: log2 of image side; pixel_addr is 2*IMG_BITS wide.
- NUM_IMAGES, 8: images in store; image_index wraps at NUM_IMAGES-1.
- PIXEL_W, 3: bits per pixel.
- WIN_X0, 231 / WIN_Y0, 36 / WIN_SIZE, 481: inclusive window origin and side in display pixels.
- ANIM_DIV, 16: sysclk cycles per wipe step (>=1).
- AUTOPLAY_CYCLES, 50000000: idle cycles before auto-advance (optional feature only).

Ports:
- sysclk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_code  in  3  0 nop, 1 prev, 2 next, 3 rot cw, 4 negative toggle, 5 rot ccw, 6 mirror toggle, 7 view reset
- cmd_ready  out  1  pending slot empty
- busy  out  1  wipe in progress
- display_addr  in  22  [21:11] x, [10:0] y
- mapper_pixel_x / mapper_pixel_y  in  IMG_BITS  image coordinate from mapper
- pixel_data  in  PIXEL_W  image store data
- mapper_display_addr  out  22  display_addr passthrough
- pixel_addr  out  2*IMG_BITS  image store address
- image_index  out  clog2(NUM_IMAGES)  image store select
- display_data  out  PIXEL_W  pixel to VGA timing block

Behaviour:
- Reset values: cur_img 0, rot 0, neg 0, mirror 0, state IDLE, anim_idx 0, prescaler 0, pending empty, cmd_ready 1, busy 0.
- Handshake: a command is accepted on a cycle where cmd_valid && cmd_ready and cmd_code != 0.
- In IDLE, an accepted command executes on that edge.
- In ANIM, an accepted command is stored in pending, and cmd_ready drops the next cycle.
- Pending executes on the first IDLE cycle after ANIM ends. A new command is not accepted on that cycle.
- prev: cur_img decrements, wrapping 0 -> NUM_IMAGES-1. Also rot=0, neg=0, mirror=0, anim_idx=MAX (2^(2*IMG_BITS)-1), dir=down, state ANIM.
- next: cur_img increments, wrapping NUM_IMAGES-1 -> 0. Also clears rot/neg/mirror, anim_idx=0, dir=up, state ANIM.
- Rot cw: rot+1 mod 4. Rot ccw: rot-1 mod 4. Negative and mirror: toggle. View reset: rot/neg/mirror 0, cur_img kept.
- ANIM: the prescaler counts 0..ANIM_DIV-1. On wrap, anim_idx steps ±1 per dir.
- ANIM ends on the step where anim_idx is at its terminal value (MAX for up, 0 for down): state returns to IDLE and anim_idx is left at that terminal value.
- busy=1 for exactly 2^(2*IMG_BITS)*ANIM_DIV cycles.
- Address transform (combinational; MAX_C = 2^IMG_BITS-1):
  - mirror first: x=MAX_C-x.
  - rot 0: {y,x}; 1: {x,MAX_C-y}; 2: {MAX_C-y,MAX_C-x}; 3: {MAX_C-x,y}.
  - All arithmetic is IMG_BITS wide, with no overflow.
- Image select:
  - IDLE: cur_img.
  - ANIM up: cur_img if pixel_addr < anim_idx, else the previous image.
  - ANIM down: cur_img if pixel_addr > anim_idx, else the next image.
  - Neighbour images wrap as above.
- Window: outside [WIN_X0, WIN_X0+WIN_SIZE-1] x [WIN_Y0, WIN_Y0+WIN_SIZE-1], display_data=0.
- Inside the window, display_data = neg ? ~pixel_data : pixel_data.
- All combinational outputs are assigned on every path; no latches.
- While reset is high, display_data=0.
- Reset mid-ANIM aborts the wipe and clears pending the same edge.

Optional Feature:
- F3_GPU_AUTOPLAY_EN defined: a counter runs while IDLE with pending empty and no command accepted. On reaching AUTOPLAY_CYCLES-1 it issues an internal next and clears. Any accepted command clears the counter.
- Undefined: no counter or logic; the AUTOPLAY_CYCLES parameter is ignored.

Decomposition:
- Package f3_gpu_pkg: command code constants, state encoding (IDLE/ANIM), rotation encoding, wipe direction.
- One combinational sub-module f3_gpu_xform (mirror+rotate, parametrised IMG_BITS).
- Control, prescaler and pending buffer stay in f3_gpu.

Test Plan (IMG_BITS=4, NUM_IMAGES=8, ANIM_DIV=2):
- Reset, cmd 2 -> image_index 1, busy high exactly 512 cycles. At mid-wipe anim_idx=0x80: pixel_addr 0x7F selects 1, pixel_addr 0x80 selects 0.
- From reset, cmd 1 -> cur_img 7 (wrap); wipe counts down from 0xFF, then busy=0.
- mapper x=1,y=2: rot0 -> 0x21; cmd 3 -> 0x1D; cmd 6 then rot0 (via cmd 7, 6) -> 0x2E.
- During wipe, cmd 2 accepted -> cmd_ready=0. A further cmd 4 is held off. The second wipe starts the cycle after the first ends, and cur_img=2.
- display_addr x=230 -> display_data 0. Inside the window with cmd 4 and pixel_data 3'b101 -> 3'b010.
- Reset asserted at wipe step 100 -> next cycle busy=0, cmd_ready=1, cur_img=0, anim_idx=0.

Source files
------------

// File: rtl/f3_gpu_pkg.sv
// rtl/f3_gpu_pkg.sv - shared command codes and encodings for the f3 image viewer GPU
package f3_gpu_pkg;

  localparam logic [2:0] CMD_NOP      = 3'd0;
  localparam logic [2:0] CMD_PREV     = 3'd1;
  localparam logic [2:0] CMD_NEXT     = 3'd2;
  localparam logic [2:0] CMD_ROT_CW   = 3'd3;
  localparam logic [2:0] CMD_NEG      = 3'd4;
  localparam logic [2:0] CMD_ROT_CCW  = 3'd5;
  localparam logic [2:0] CMD_MIRROR   = 3'd6;
  localparam logic [2:0] CMD_VIEW_RST = 3'd7;

  typedef enum logic {ST_IDLE, ST_ANIM} state_t;
  typedef enum logic [1:0] {ROT_0, ROT_90, ROT_180, ROT_270} rot_t;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

endpackage

// File: rtl/f3_gpu_xform.sv
// rtl/f3_gpu_xform.sv - mirror then rotate an image coordinate into a pixel store address
module f3_gpu_xform
  import f3_gpu_pkg::*;
#(
  parameter int IMG_BITS = 4
) (
  input  logic [IMG_BITS-1:0]   i_x,
  input  logic [IMG_BITS-1:0]   i_y,
  input  logic                  i_mirror,
  input  rot_t                  i_rot,
  output logic [2*IMG_BITS-1:0] o_addr
);

  logic [IMG_BITS-1:0] w_x;

  // MAX_C - v equals bitwise inversion at IMG_BITS width
  assign w_x = i_mirror ? ~i_x : i_x;

  always_comb begin
    o_addr = {i_y, w_x};
    case (i_rot)
      ROT_0:   o_addr = {i_y, w_x};
      ROT_90:  o_addr = {w_x, ~i_y};
      ROT_180: o_addr = {~i_y, ~w_x};
      ROT_270: o_addr = {~w_x, i_y};
    endcase
  end

endmodule

// File: rtl/f3_gpu.sv
// rtl/f3_gpu.sv - image viewer GPU: command handshake, wipe animation, windowed pixel output
// Optional autoplay auto-advance is built when F3_GPU_AUTOPLAY_EN is defined.
module f3_gpu
  import f3_gpu_pkg::*;
#(
  parameter int IMG_BITS        = 4,
  parameter int NUM_IMAGES      = 8,
  parameter int PIXEL_W         = 3,
  parameter int WIN_X0          = 231,
  parameter int WIN_Y0          = 36,
  parameter int WIN_SIZE        = 481,
  parameter int ANIM_DIV        = 16,
  parameter int AUTOPLAY_CYCLES = 50000000,
  localparam int IW             = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1,
  localparam int AW             = 2 * IMG_BITS
) (
  input  logic                sysclk,
  input  logic                reset,
  input  logic                cmd_valid,
  input  logic [2:0]          cmd_code,
  output logic                cmd_ready,
  output logic                busy,
  input  logic [21:0]         display_addr,
  input  logic [IMG_BITS-1:0] mapper_pixel_x,
  input  logic [IMG_BITS-1:0] mapper_pixel_y,
  input  logic [PIXEL_W-1:0]  pixel_data,
  output logic [21:0]         mapper_display_addr,
  output logic [AW-1:0]       pixel_addr,
  output logic [IW-1:0]       image_index,
  output logic [PIXEL_W-1:0]  display_data
);

  localparam int PW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [11:0] WX0 = 12'(WIN_X0);
  localparam logic [11:0] WX1 = 12'(WIN_X0 + WIN_SIZE - 1);
  localparam logic [11:0] WY0 = 12'(WIN_Y0);
  localparam logic [11:0] WY1 = 12'(WIN_Y0 + WIN_SIZE - 1);

  if (AUTOPLAY_CYCLES < 1 || ANIM_DIV < 1) begin : g_param_check
    $error("f3_gpu: AUTOPLAY_CYCLES and ANIM_DIV must be >= 1");
  end

  state_t           r_state;
  dir_t             r_dir;
  rot_t             r_rot;
  logic             r_neg;
  logic             r_mirror;
  logic [IW-1:0]    r_cur_img;
  logic [AW-1:0]    r_anim_idx;
  logic [PW-1:0]    r_presc;
  logic             r_pend_valid;
  logic [2:0]       r_pend_code;

  logic             w_accept;
  logic             w_auto_fire;
  logic             w_exec_valid;
  logic [2:0]       w_exec_code;
  logic [IW-1:0]    w_img_prev;
  logic [IW-1:0]    w_img_next;
  logic [AW-1:0]    w_terminal;
  logic             w_in_win;

  assign cmd_ready           = !r_pend_valid;
  assign busy                = (r_state == ST_ANIM);
  assign mapper_display_addr = display_addr;
  assign w_accept            = cmd_valid && cmd_ready && (cmd_code != CMD_NOP);
  assign w_img_prev          = (r_cur_img == '0) ? IW'(NUM_IMAGES - 1) : r_cur_img - IW'(1);
  assign w_img_next          = (r_cur_img == IW'(NUM_IMAGES - 1)) ? '0 : r_cur_img + IW'(1);
  assign w_terminal          = (r_dir == DIR_UP) ? '1 : '0;

  // A held pending command wins; cmd_ready is low then, so w_accept cannot also fire
  assign w_exec_valid = (r_state == ST_IDLE) && (r_pend_valid || w_accept || w_auto_fire);
  assign w_exec_code  = r_pend_valid ? r_pend_code : (w_accept ? cmd_code : CMD_NEXT);

`ifdef F3_GPU_AUTOPLAY_EN
  localparam int APW = $clog2(AUTOPLAY_CYCLES + 1);
  logic [APW-1:0] r_auto_cnt;

  assign w_auto_fire = (r_state == ST_IDLE) && !r_pend_valid && !w_accept &&
                       (r_auto_cnt == APW'(AUTOPLAY_CYCLES - 1));

  always_ff @(posedge sysclk) begin
    if (reset || w_accept || w_auto_fire) r_auto_cnt <= '0;
    else if (r_state == ST_IDLE && !r_pend_valid) r_auto_cnt <= r_auto_cnt + APW'(1);
  end
`else
  assign w_auto_fire = 1'b0;
`endif

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_dir        <= DIR_UP;
      r_rot        <= ROT_0;
      r_neg        <= 1'b0;
      r_mirror     <= 1'b0;
      r_cur_img    <= '0;
      r_anim_idx   <= '0;
      r_presc      <= '0;
      r_pend_valid <= 1'b0;
      r_pend_code  <= CMD_NOP;
    end else if (w_exec_valid) begin
      r_pend_valid <= 1'b0;
      case (w_exec_code)
        CMD_PREV: begin
          r_cur_img  <= w_img_prev;
          r_rot      <= ROT_0;
          r_neg      <= 1'b0;
          r_mirror   <= 1'b0;
          r_anim_idx <= '1;
          r_dir      <= DIR_DOWN;
          r_presc    <= '0;
          r_state    <= ST_ANIM;
        end
        CMD_NEXT: begin
          r_cur_img  <= w_img_next;
          r_rot      <= ROT_0;
          r_neg      <= 1'b0;
          r_mirror   <= 1'b0;
          r_anim_idx <= '0;
          r_dir      <= DIR_UP;
          r_presc    <= '0;
          r_state    <= ST_ANIM;
        end
        CMD_ROT_CW:  r_rot    <= rot_t'(r_rot + 2'd1);
        CMD_ROT_CCW: r_rot    <= rot_t'(r_rot - 2'd1);
        CMD_NEG:     r_neg    <= !r_neg;
        CMD_MIRROR:  r_mirror <= !r_mirror;
        CMD_VIEW_RST: begin
          r_rot    <= ROT_0;
          r_neg    <= 1'b0;
          r_mirror <= 1'b0;
        end
        default: ;
      endcase
    end else if (r_state == ST_ANIM) begin
      if (w_accept) begin
        r_pend_valid <= 1'b1;
        r_pend_code  <= cmd_code;
      end
      if (r_presc == PW'(ANIM_DIV - 1)) begin
        r_presc <= '0;
        if (r_anim_idx == w_terminal) r_state <= ST_IDLE;
        else if (r_dir == DIR_UP) r_anim_idx <= r_anim_idx + AW'(1);
        else r_anim_idx <= r_anim_idx - AW'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  f3_gpu_xform #(.IMG_BITS(IMG_BITS)) u_xform (
    .i_x      (mapper_pixel_x),
    .i_y      (mapper_pixel_y),
    .i_mirror (r_mirror),
    .i_rot    (r_rot),
    .o_addr   (pixel_addr)
  );

  always_comb begin
    image_index = r_cur_img;
    if (r_state == ST_ANIM) begin
      if (r_dir == DIR_UP) image_index = (pixel_addr < r_anim_idx) ? r_cur_img : w_img_prev;
      else image_index = (pixel_addr > r_anim_idx) ? r_cur_img : w_img_next;
    end
  end

  assign w_in_win = ({1'b0, display_addr[21:11]} >= WX0) && ({1'b0, display_addr[21:11]} <= WX1) &&
                    ({1'b0, display_addr[10:0]}  >= WY0) && ({1'b0, display_addr[10:0]}  <= WY1);

  always_comb begin
    display_data = '0;
    if (!reset && w_in_win) display_data = r_neg ? ~pixel_data : pixel_data;
  end

endmodule

// File: tb/tb_f3_gpu.sv
// tb/tb_f3_gpu.sv - directed scoreboard bench for f3_gpu (IMG_BITS=4, NUM_IMAGES=8, ANIM_DIV=2)
module tb_f3_gpu;

  logic        sysclk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_code = 3'd0;
  logic        cmd_ready;
  logic        busy;
  logic [21:0] display_addr = '0;
  logic [3:0]  mapper_pixel_x = '0;
  logic [3:0]  mapper_pixel_y = '0;
  logic [2:0]  pixel_data = '0;
  logic [21:0] mapper_display_addr;
  logic [7:0]  pixel_addr;
  logic [2:0]  image_index;
  logic [2:0]  display_data;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cnt;

  f3_gpu #(.IMG_BITS(4), .NUM_IMAGES(8), .PIXEL_W(3), .ANIM_DIV(2)) dut (
    .sysclk              (sysclk),
    .reset               (reset),
    .cmd_valid           (cmd_valid),
    .cmd_code            (cmd_code),
    .cmd_ready           (cmd_ready),
    .busy                (busy),
    .display_addr        (display_addr),
    .mapper_pixel_x      (mapper_pixel_x),
    .mapper_pixel_y      (mapper_pixel_y),
    .pixel_data          (pixel_data),
    .mapper_display_addr (mapper_display_addr),
    .pixel_addr          (pixel_addr),
    .image_index         (image_index),
    .display_data        (display_data)
  );

  always #5 sysclk = ~sysclk;

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic send(input logic [2:0] c);
    cmd_valid = 1'b1;
    cmd_code  = c;
    tick(1);
    cmd_valid = 1'b0;
    cmd_code  = 3'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic wait_idle(inout int n);
    while (busy === 1'b1 && n < 2000) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    display_addr = {11'd300, 11'd300};
    pixel_data   = 3'b111;
    tick(2);
    expect_v("rst_display_data", 0);  chk(display_data);
    reset = 1'b0;
    #1;
    expect_v("rst_cmd_ready", 1);     chk(cmd_ready);
    expect_v("rst_busy", 0);          chk(busy);
    expect_v("rst_image_index", 0);   chk(image_index);
    expect_v("rst_anim_idx", 0);      chk(dut.r_anim_idx);
    expect_v("passthrough", {11'd300, 11'd300}); chk(mapper_display_addr);
    expect_v("in_win_plain", 7);      chk(display_data);

    // next: wipe up, mid-point split at anim_idx 0x80
    expect_v("next_busy", 1);
    send(3'd2);
    chk(busy);
    cnt = 0;
    while (busy === 1'b1 && cnt < 2000) begin
      tick(1);
      cnt++;
      if (cnt == 256) begin
        expect_v("mid_anim_idx", 'h80); chk(dut.r_anim_idx);
        mapper_pixel_y = 4'h7; mapper_pixel_x = 4'hF; #1;
        expect_v("mid_sel_7f", 1);      chk(image_index);
        mapper_pixel_y = 4'h8; mapper_pixel_x = 4'h0; #1;
        expect_v("mid_sel_80", 0);      chk(image_index);
        mapper_pixel_y = 4'h0;
      end
    end
    expect_v("next_busy_cycles", 512);  chk(cnt);
    expect_v("next_image_index", 1);    chk(image_index);
    expect_v("next_anim_end", 'hFF);    chk(dut.r_anim_idx);

    // prev from reset wraps to image 7, wipe counts down
    do_reset();
    send(3'd1);
    expect_v("prev_cur_img", 7);        chk(dut.r_cur_img);
    expect_v("prev_anim_start", 'hFF);  chk(dut.r_anim_idx);
    expect_v("prev_sel_next", 0);       chk(image_index);
    tick(2);
    expect_v("prev_anim_step", 'hFE);   chk(dut.r_anim_idx);
    cnt = 2;
    wait_idle(cnt);
    expect_v("prev_busy_cycles", 512);  chk(cnt);
    expect_v("prev_anim_end", 0);       chk(dut.r_anim_idx);
    expect_v("prev_image_index", 7);    chk(image_index);

    // address transform
    do_reset();
    mapper_pixel_x = 4'd1; mapper_pixel_y = 4'd2; #1;
    expect_v("xf_rot0", 'h21);          chk(pixel_addr);
    send(3'd3);
    expect_v("xf_rot1", 'h1D);          chk(pixel_addr);
    send(3'd7); send(3'd6);
    expect_v("xf_mirror_rot0", 'h2E);   chk(pixel_addr);
    send(3'd7); send(3'd5);
    expect_v("xf_rot3", 'hE2);          chk(pixel_addr);

    // pending buffer during a wipe
    do_reset();
    mapper_pixel_x = 4'd0; mapper_pixel_y = 4'd0;
    send(3'd2);
    tick(10);
    send(3'd2);
    expect_v("pend_ready_low", 0);      chk(cmd_ready);
    cmd_valid = 1'b1; cmd_code = 3'd4;
    tick(5);
    expect_v("pend_neg_held", 0);       chk(dut.r_neg);
    expect_v("pend_ready_still_low", 0); chk(cmd_ready);
    cmd_valid = 1'b0; cmd_code = 3'd0;
    cnt = 0;
    wait_idle(cnt);
    expect_v("pend_first_cycles", 496); chk(cnt);
    expect_v("pend_gap_ready", 0);      chk(cmd_ready);
    expect_v("pend_gap_img", 1);        chk(dut.r_cur_img);
    tick(1);
    expect_v("pend_second_busy", 1);    chk(busy);
    expect_v("pend_second_img", 2);     chk(dut.r_cur_img);
    expect_v("pend_second_ready", 1);   chk(cmd_ready);
    cnt = 0;
    wait_idle(cnt);
    expect_v("pend_second_cycles", 512); chk(cnt);

    // window edges and negative
    do_reset();
    pixel_data = 3'b101;
    display_addr = {11'd230, 11'd100}; #1;
    expect_v("win_x_left_out", 0);      chk(display_data);
    display_addr = {11'd231, 11'd36}; #1;
    expect_v("win_corner_lo", 5);       chk(display_data);
    display_addr = {11'd711, 11'd516}; #1;
    expect_v("win_corner_hi", 5);       chk(display_data);
    display_addr = {11'd712, 11'd516}; #1;
    expect_v("win_x_right_out", 0);     chk(display_data);
    display_addr = {11'd711, 11'd517}; #1;
    expect_v("win_y_bottom_out", 0);    chk(display_data);
    send(3'd4);
    display_addr = {11'd300, 11'd300}; #1;
    expect_v("win_negative", 2);        chk(display_data);
    display_addr = {11'd300, 11'd35}; #1;
    expect_v("win_y_top_out", 0);       chk(display_data);

    // reset in the middle of a wipe with a command pending
    do_reset();
    display_addr = {11'd300, 11'd300};
    send(3'd2);
    send(3'd2);
    tick(199);
    expect_v("mid_reset_anim_before", 100); chk(dut.r_anim_idx);
    expect_v("mid_reset_pend_before", 0);   chk(cmd_ready);
    reset = 1'b1;
    tick(1);
    expect_v("mid_reset_busy", 0);      chk(busy);
    expect_v("mid_reset_ready", 1);     chk(cmd_ready);
    expect_v("mid_reset_cur_img", 0);   chk(dut.r_cur_img);
    expect_v("mid_reset_anim", 0);      chk(dut.r_anim_idx);
    expect_v("mid_reset_display", 0);   chk(display_data);
    reset = 1'b0;
    tick(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
